// File: rtl/d_latch_checker_if.sv
// Signals between the checker and the D latch under test.
// The checker drives enable/data; the latch returns q and q_n.
interface d_latch_checker_if;
  logic lat_en;
  logic lat_d;
  logic lat_q;
  logic lat_q_n;

  modport master (
    output lat_en,
    output lat_d,
    input  lat_q,
    input  lat_q_n
  );

  modport slave (
    input  lat_en,
    input  lat_d,
    output lat_q,
    output lat_q_n
  );
endinterface

// File: rtl/d_latch_checker.sv
// Self-checking driver for a D latch: applies LFSR (enable, data) vectors,
// waits a settle window, and compares q/q_n against a transparent/hold model.
module d_latch_checker #(
  parameter int          N_VECTORS     = 8,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [3:0]  SEED          = 4'b1001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  d_latch_checker_if.master        lat,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_count,
  output logic [7:0]               vec_index
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY_EN = 3'd1,
    APPLY_D  = 3'd2,
    SETTLE   = 3'd3,
    CHECK    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic        exp_q, exp_d;
  logic        lat_en_q, lat_en_d;
  logic        lat_dat_q, lat_dat_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic        vec_en_s;
  logic        vec_dat_s;
  logic        exp_s;
  logic        match_s;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // Vector 0 forces enable so the reference model starts from a known value.
  assign vec_en_s  = (idx_q == 8'd0) ? 1'b1 : lfsr_q[0];
  assign vec_dat_s = lfsr_q[1];
  assign exp_s     = vec_en_s ? vec_dat_s : exp_q;
  // Written as a positive match so an unknown q falls into the mismatch branch.
  assign match_s   = (lat.lat_q == exp_s) && (lat.lat_q_n != lat.lat_q);

  // Next-state and datapath updates for the vector sequencer.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    exp_d     = exp_q;
    lat_en_d  = lat_en_q;
    lat_dat_d = lat_dat_q;
    err_d     = err_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY_EN;
          err_d   = 8'd0;
          idx_d   = 8'd0;
          lfsr_d  = SEED;
        end else begin
          state_d = state_q;
        end
      end
      APPLY_EN: begin
        lat_en_d = vec_en_s;
        state_d  = APPLY_D;
      end
      APPLY_D: begin
        lat_dat_d = vec_dat_s;
        cnt_d     = 4'd0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        exp_d = exp_s;
        if (match_s) begin
          err_d = err_q;
        end else if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end else begin
          err_d = err_q;
        end
        if (idx_q == 8'(N_VECTORS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          lfsr_d  = lfsr_next(lfsr_q);
          state_d = APPLY_EN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 8'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      exp_q     <= 1'b0;
      lat_en_q  <= 1'b0;
      lat_dat_q <= 1'b0;
      err_q     <= 8'd0;
      idx_q     <= 8'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      exp_q     <= exp_d;
      lat_en_q  <= lat_en_d;
      lat_dat_q <= lat_dat_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign lat.lat_en = lat_en_q;
  assign lat.lat_d  = lat_dat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign vec_index  = idx_q;

endmodule

// File: tb/tb_d_latch_checker.sv
// Scoreboard bench for d_latch_checker driving a behavioural latch with
// selectable faults; a second instance covers the single-vector case.
module tb_d_latch_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fault = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  d_latch_checker_if a_if ();
  d_latch_checker_if b_if ();

  logic       a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [7:0] a_err, a_vi, b_err, b_vi;

  d_latch_checker u_a (
    .clk(clk), .rst(rst), .start(start_a), .lat(a_if),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err), .vec_index(a_vi)
  );

  d_latch_checker #(.N_VECTORS(1), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .lat(b_if),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err), .vec_index(b_vi)
  );

  // Behavioural latches; fault 1: q0/qn1, 2: qn=q, 3: q=d always.
  logic model_a, model_b;
  always_latch if (a_if.lat_en) model_a <= a_if.lat_d;
  always_latch if (b_if.lat_en) model_b <= b_if.lat_d;

  always_comb begin
    case (fault)
      1:       begin a_if.lat_q = 1'b0;        a_if.lat_q_n = 1'b1;         end
      2:       begin a_if.lat_q = model_a;     a_if.lat_q_n = model_a;      end
      3:       begin a_if.lat_q = a_if.lat_d;  a_if.lat_q_n = ~a_if.lat_d;  end
      default: begin a_if.lat_q = model_a;     a_if.lat_q_n = ~model_a;     end
    endcase
  end
  assign b_if.lat_q   = model_b;
  assign b_if.lat_q_n = ~model_b;

  typedef struct {
    int         done_cyc;
    logic [7:0] err;
    logic       pass;
    logic       en;
    logic       d;
  } exp_t;

  exp_t       sq_a[$];
  exp_t       sq_b[$];
  logic [1:0] vq_a[$];

  // Reference vectors, bit k = vector k.
  logic [7:0] ref_en = 8'b11101011;
  logic [7:0] ref_d  = 8'b11010110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance A: per-vector latch drive and end-of-run results.
  logic       a_done_prev = 1'b0;
  logic [7:0] a_vi_prev = 8'd0;
  logic [1:0] a_v;
  exp_t       a_e;
  always @(negedge clk) begin
    if ((a_busy && a_vi == 8'(a_vi_prev + 8'd1)) || (a_done && !a_done_prev)) begin
      check("a_vec_pending", vq_a.size() > 0, 1);
      if (vq_a.size() > 0) begin
        a_v = vq_a.pop_front();
        check("a_lat_en", a_if.lat_en, a_v[1]);
        check("a_lat_d", a_if.lat_d, a_v[0]);
      end
    end
    if (a_done && !a_done_prev) begin
      check("a_done_pending", sq_a.size() > 0, 1);
      if (sq_a.size() > 0) begin
        a_e = sq_a.pop_front();
        check("a_done_cycle", cyc, a_e.done_cyc);
        check("a_err_count", a_err, a_e.err);
        check("a_pass", a_pass, a_e.pass);
      end
    end
    a_done_prev <= a_done;
    a_vi_prev   <= a_vi;
  end

  // Monitor for instance B: end-of-run results including final latch drive.
  logic b_done_prev = 1'b0;
  exp_t b_e;
  always @(negedge clk) begin
    if (b_done && !b_done_prev) begin
      check("b_done_pending", sq_b.size() > 0, 1);
      if (sq_b.size() > 0) begin
        b_e = sq_b.pop_front();
        check("b_done_cycle", cyc, b_e.done_cyc);
        check("b_err_count", b_err, b_e.err);
        check("b_pass", b_pass, b_e.pass);
        check("b_lat_en", b_if.lat_en, b_e.en);
        check("b_lat_d", b_if.lat_d, b_e.d);
      end
    end
    b_done_prev <= b_done;
  end

  task automatic run_a(input logic [7:0] exp_err, input bit expect_done);
    exp_t e;
    start_a = 1'b1;
    for (int k = 0; k < 8; k++) vq_a.push_back({ref_en[k], ref_d[k]});
    if (expect_done) begin
      e.done_cyc = cyc + 1 + 8 * 5;
      e.err = exp_err;
      e.pass = (exp_err == 8'd0);
      e.en = 1'b1;
      e.d = 1'b1;
      sq_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 500 && !a_done; i++) @(negedge clk);
    check("a_done_timeout", a_done, 1);
  endtask

  task automatic run_b();
    exp_t e;
    start_b = 1'b1;
    e.done_cyc = cyc + 1 + 4;
    e.err = 8'd0;
    e.pass = 1'b1;
    e.en = 1'b1;
    e.d = 1'b0;
    sq_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 100 && !b_done; i++) @(negedge clk);
    check("b_done_timeout", b_done, 1);
  endtask

  task automatic check_a_cleared(input string tag);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_pass"}, a_pass, 0);
    check({tag, "_err"}, a_err, 0);
    check({tag, "_vi"}, a_vi, 0);
    check({tag, "_lat_en"}, a_if.lat_en, 0);
    check({tag, "_lat_d"}, a_if.lat_d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_a_cleared("reset");
    check("reset_b_done", b_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good latch, then the three fault models with hand-counted errors.
    fault = 0; run_a(8'd0, 1'b1); wait_done_a();
    fault = 1; run_a(8'd4, 1'b1); wait_done_a();
    fault = 2; run_a(8'd8, 1'b1); wait_done_a();
    fault = 3; run_a(8'd1, 1'b1); wait_done_a();

    // Abort a run by reset at cycle 12, with an ignored start while busy.
    fault = 1;
    run_a(8'd0, 1'b0);
    repeat (3) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("live_err_count", a_err, 1);
    check("live_vec_index", a_vi, 2);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check_a_cleared("abort");
    vq_a.delete();

    fault = 0;
    run_a(8'd0, 1'b1);
    repeat (6) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (12) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_done_a();

    // Single-vector instance, then a rerun from DONE.
    run_b();
    run_b();

    repeat (3) @(negedge clk);
    check("a_results_drained", sq_a.size(), 0);
    check("a_vectors_drained", vq_a.size(), 0);
    check("b_results_drained", sq_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
